// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-back scheduler for the 8x16 LC-3 register file.
// Round-robin arbitration of NREQ write-back sources onto the single write
// port, plus a per-register busy scoreboard for RAW/WAW stall detection.
//
// Ports:
//   Clk, Reset_n          clock (rising edge), async active-low reset
//   req_valid/dr/data     NREQ packed write-back requests
//   req_ready             one-hot combinational grant
//   rsv_valid, rsv_dr     destination reservation from issue
//   rsv_ok                reservation accepted (combinational)
//   chk_sr1/2, chk_en     issue source operands to check
//   hazard                issue must stall (combinational)
//   wb_dr/ld/data         registered register-file write port
//   busy                  scoreboard, 1 bit per register
//   wb_err                sticky: write-back to a non-busy register
//   fwd_hit, fwd_data     bypass of the in-flight write (WB_FWD_EN only)
//
// Optional feature macro: WB_FWD_EN (same-cycle forwarding of wb_data).

module regfile_wb_sched #(
    parameter int NREQ = 3,
    parameter int DW   = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_dr,
    input  logic [DW*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              rsv_valid,
    input  logic [2:0]        rsv_dr,
    output logic              rsv_ok,
    input  logic [2:0]        chk_sr1,
    input  logic [2:0]        chk_sr2,
    input  logic [1:0]        chk_en,
    output logic              hazard,
`ifdef WB_FWD_EN
    output logic [1:0]        fwd_hit,
    output logic [DW-1:0]     fwd_data,
`endif
    output logic [2:0]        wb_dr,
    output logic              wb_ld,
    output logic [DW-1:0]     wb_data,
    output logic [7:0]        busy,
    output logic              wb_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wb_ld_q, wb_ld_d;
    logic [2:0]      wb_dr_q, wb_dr_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic [7:0]      busy_q, busy_d;
    logic            wb_err_q, wb_err_d;

    logic [NREQ-1:0] grant;
    logic            found;
    logic [2:0]      sel_dr;
    logic [DW-1:0]   sel_data;
    int              idx;
    int              nxt;

    // Round-robin search: first valid requester at or after rr_ptr wins.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        sel_dr   = '0;
        sel_data = '0;
        idx      = 0;
        nxt      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                sel_dr     = req_dr[3*idx +: 3];
                sel_data   = req_data[DW*idx +: DW];
                nxt        = (idx + 1 == NREQ) ? 0 : idx + 1;
            end
        end
    end

    assign req_ready = grant;
    assign rsv_ok    = rsv_valid & ~busy_q[rsv_dr];

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wb_ld_d   = found;
        wb_dr_d   = wb_dr_q;
        wb_data_d = wb_data_q;
        if (found) begin
            rr_ptr_d  = PW'(nxt);
            wb_dr_d   = sel_dr;
            wb_data_d = sel_data;
        end
    end

    // Clear for the write retiring now, then set for the new reservation,
    // so a simultaneous set on the same register wins.
    always_comb begin
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (wb_ld_q) begin
            busy_d[wb_dr_q] = 1'b0;
            if (!busy_q[wb_dr_q]) begin
                wb_err_d = 1'b1;
            end
        end
        if (rsv_ok) begin
            busy_d[rsv_dr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr_q  <= '0;
            wb_ld_q   <= 1'b0;
            wb_dr_q   <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_ld_q   <= wb_ld_d;
            wb_dr_q   <= wb_dr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign wb_ld   = wb_ld_q;
    assign wb_dr   = wb_dr_q;
    assign wb_data = wb_data_q;
    assign busy    = busy_q;
    assign wb_err  = wb_err_q;

`ifdef WB_FWD_EN
    logic hit1, hit2;

    // A source matching the write in flight is satisfied by the bypass.
    assign hit1     = chk_en[0] & wb_ld_q & (chk_sr1 == wb_dr_q);
    assign hit2     = chk_en[1] & wb_ld_q & (chk_sr2 == wb_dr_q);
    assign fwd_hit  = {hit2, hit1};
    assign fwd_data = wb_data_q;
    assign hazard   = (chk_en[0] & busy_q[chk_sr1] & ~hit1)
                    | (chk_en[1] & busy_q[chk_sr2] & ~hit2);
`else
    assign hazard = (chk_en[0] & busy_q[chk_sr1])
                  | (chk_en[1] & busy_q[chk_sr2]);
`endif

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler for the 8x16 LC-3 register file.
- Shares the file's single write port (destination select, load enable, write data) between NREQ write-back requesters, e.g. ALU, memory load, PC-link.
- Keeps a per-register busy scoreboard so the issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory sources and the register file; its registered outputs drive the register file's write port directly.

Parameters:
- NREQ, 3, number of write-back requesters (2..4); index 0 has highest priority after reset.
- DW, 16, data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_dr  in  3*NREQ  destination register of requester i, bits [3i+2:3i].
- req_data  in  DW*NREQ  write data of requester i, bits [DW*i+DW-1:DW*i].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready in the same cycle.
- rsv_valid  in  1  issue logic reserves destination rsv_dr.
- rsv_dr  in  3  register to reserve.
- rsv_ok  out  1  combinational; reservation accepted this cycle.
- chk_sr1, chk_sr2  in  3 each  source registers of the instruction being issued.
- chk_en  in  2  bit0 enables the chk_sr1 check, bit1 enables the chk_sr2 check.
- hazard  out  1  combinational; issue must stall.
- wb_dr  out  3  to the register file destination select.
- wb_ld  out  1  to the register file load enable.
- wb_data  out  DW  to the register file data input.
- busy  out  8  scoreboard, for debug.
- wb_err  out  1  sticky flag: write-back to a register that was not busy.

Behaviour:
- Reset, asynchronous: busy=0, wb_ld=0, wb_dr=0, wb_data=0, rr_ptr=0, wb_err=0. Any grant in flight is dropped.
- Arbitration, combinational:
  - Round-robin over req_valid, starting at rr_ptr.
  - Exactly one req_ready bit is high when any req_valid is high; none otherwise.
  - req_ready never depends on rsv_* or chk_*.
- Pipeline, 1-cycle latency:
  - A grant for requester g in cycle N registers wb_dr=req_dr[g], wb_data=req_data[g] and wb_ld=1, all visible in cycle N+1.
  - The register file captures the data at the end of N+1.
  - With no grant, wb_ld=0 in N+1. wb_dr and wb_data hold their previous values.
- rr_ptr: after a grant to g, rr_ptr becomes (g+1) mod NREQ. It is unchanged when there is no grant.
- Throughput: one write per cycle; back-to-back grants are allowed.
- Scoreboard:
  - rsv_ok = rsv_valid & ~busy[rsv_dr]. A WAW stall occurs when the target is already busy, even if its clear happens this same cycle.
  - When rsv_ok is high, busy[rsv_dr] is set at the clock edge.
  - When wb_ld is high, busy[wb_dr] is cleared at the clock edge.
  - Same register set and cleared in one cycle: set wins (busy stays 1). This case cannot arise through rsv_ok because of the WAW rule; it is kept for robustness.
  - wb_ld=1 with busy[wb_dr]=0: the write still occurs, busy is unchanged, and wb_err latches 1 until reset.
- Hazard: hazard = (chk_en[0] & busy[chk_sr1]) | (chk_en[1] & busy[chk_sr2]). No bypass in the base build.
- Same requester held valid: it is re-granted only when its round-robin turn comes. A requester must hold req_dr and req_data stable while valid and not ready.
- NREQ=1 degenerates to req_ready = req_valid.

Optional Feature:
- Macro: WB_FWD_EN.
- Enabled:
  - Adds outputs fwd_hit (2 bits) and fwd_data (DW).
  - While wb_ld=1, a checked source equal to wb_dr has its hazard term suppressed. The corresponding fwd_hit bit is high and fwd_data=wb_data, so issue proceeds in the same cycle.
  - If both sources hit, both fwd_hit bits are high and share fwd_data.
- Disabled: the ports are absent and hazard is exactly the base equation.

Test Plan:
1. Reset then idle: all outputs 0 and busy=8'h00. Assert Reset_n low while wb_ld=1: wb_ld drops to 0 immediately (asynchronous).
2. rsv_valid with rsv_dr=3 -> rsv_ok=1, busy=8'h08. Next cycle, chk_sr1=3 with chk_en=01 -> hazard=1. Requester 1 writes R3=16'hBEEF: req_ready[1] in N, wb_ld=1 with wb_dr=3 and wb_data=16'hBEEF in N+1, busy=8'h00 in N+2, hazard=0.
3. NREQ=3, all valid continuously -> grants 0,1,2,0,1; wb_ld held 1 for five consecutive cycles.
4. busy[5]=1 and rsv_dr=5 -> rsv_ok=0 and busy unchanged. Write-back to R5 clears busy[5]; rsv_dr=5 the following cycle -> rsv_ok=1.
5. Write-back to R2 while busy=8'h00 -> R2 is written, wb_err=1 and stays 1 until Reset_n is asserted.
6. With WB_FWD_EN: busy[4]=1, wb_ld=1, wb_dr=4, wb_data=16'h1234; chk_sr1=4, chk_sr2=4, chk_en=11 -> hazard=0, fwd_hit=11, fwd_data=16'h1234.
